// File: rtl/ccc_dyncfg_pkg.sv
// Shared types for the CCC dynamic-reconfiguration sequencer: FSM states and
// the bit positions of each PLL field inside the serial config word.
package ccc_dyncfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_UPDATE,
        ST_WAIT_LOCK
    } state_e;

    // Field LSB positions within CFG_IN, for firmware and bench word assembly
    localparam int FINDIV_LSB = 0;
    localparam int FBDIV_LSB  = 7;
    localparam int OADIV_LSB  = 14;
    localparam int OBDIV_LSB  = 19;
    localparam int OCDIV_LSB  = 24;
    localparam int OAMUX_LSB  = 29;
    localparam int OBMUX_LSB  = 32;
    localparam int OCMUX_LSB  = 35;
    localparam int FBDLY_LSB  = 38;
    localparam int FBSEL_LSB  = 43;

endpackage

// File: rtl/ccc_dyncfg_ctrl_lock_qual.sv
// PLL LOCK qualifier: 2-FF synchroniser followed by a consecutive-high counter
// that flags lock_good once lock_s has held for LOCK_STABLE cycles.
module ccc_lock_qual
    import ccc_dyncfg_pkg::*;
#(
    parameter int LOCK_STABLE = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic lock_i,
    input  logic clr_i,
    output logic lock_s_o,
    output logic lock_good_o
);

    localparam int SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam logic [SW-1:0] SMAX = SW'(LOCK_STABLE - 1);

    logic          meta_q;
    logic          sync_q;
    logic [SW-1:0] stable_q;
    logic [SW-1:0] stable_d;

    // Any low sample restarts the run; the count parks at its terminal value
    always_comb begin
        stable_d = stable_q;
        if (clr_i || !sync_q) begin
            stable_d = '0;
        end else if (stable_q != SMAX) begin
            stable_d = stable_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= '0;
        end else begin
            meta_q   <= lock_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
        end
    end

    assign lock_s_o    = sync_q;
    assign lock_good_o = sync_q && (stable_q == SMAX);

endmodule

// File: rtl/ccc_dyncfg_ctrl.sv
// Sequencer that shifts a new PLL config word into the CCC dynamic-config chain,
// captures the old word as readback, strobes SUPDATE and qualifies LOCK with retries.
module ccc_dyncfg_ctrl
    import ccc_dyncfg_pkg::*;
#(
    parameter int CFG_WIDTH    = 81,
    parameter int SCLK_DIV     = 2,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int MAX_RETRY    = 2
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             START,
    input  logic [CFG_WIDTH-1:0]             CFG_IN,
    output logic                             BUSY,
    output logic                             DONE,
    output logic                             ERR,
    output logic [$clog2(MAX_RETRY+1)-1:0]   RETRIES,
    output logic [CFG_WIDTH-1:0]             CFG_RB,
    output logic                             LOCK_OK,
    output logic                             SCLK,
    output logic                             SDIN,
    output logic                             SSHIFT,
    output logic                             SUPDATE,
    output logic                             MODE,
    input  logic                             SDOUT,
    input  logic                             LOCK
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int BW = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
    localparam int DW = $clog2(2 * SCLK_DIV);
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    state_e                 state_q;
    logic [CFG_WIDTH-1:0]   shadow_q;
    logic [CFG_WIDTH-1:0]   shift_q;
    logic [CFG_WIDTH-1:0]   rb_q;
    logic [BW-1:0]          bit_q;
    logic [DW-1:0]          div_q;
    logic [TW-1:0]          tmo_q;
    logic [RW-1:0]          retry_q;
    logic                   busy_q, done_q, err_q, mode_q;
    logic                   sclk_q, sdin_q, sshift_q, supd_q;
    logic                   lock_s, lock_good, lock_clr;

    assign lock_clr = (state_q != ST_WAIT_LOCK);

    ccc_lock_qual #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_qual (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .lock_i      (LOCK),
        .clr_i       (lock_clr),
        .lock_s_o    (lock_s),
        .lock_good_o (lock_good)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            shift_q  <= '0;
            rb_q     <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            tmo_q    <= '0;
            retry_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mode_q   <= 1'b0;
            sclk_q   <= 1'b0;
            sdin_q   <= 1'b0;
            sshift_q <= 1'b0;
            supd_q   <= 1'b0;
        end else begin
            // CCC pins are decoded from the current state, so they trail it by one cycle
            sclk_q   <= (state_q == ST_SHIFT_HI);
            sshift_q <= (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);
            sdin_q   <= ((state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI)) ? shift_q[0] : 1'b0;
            supd_q   <= (state_q == ST_UPDATE);

            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    // busy_q is still high during the DONE cycle, which also blocks START there
                    if (START && !busy_q) begin
                        shadow_q <= CFG_IN;
                        shift_q  <= CFG_IN;
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
                        retry_q  <= '0;
                        mode_q   <= 1'b1;
                        bit_q    <= '0;
                        div_q    <= '0;
                        state_q  <= ST_SHIFT_LO;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_SHIFT_LO: begin
                    if (div_q == DW'(SCLK_DIV - 1)) begin
                        div_q   <= '0;
                        state_q <= ST_SHIFT_HI;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (div_q == DW'(SCLK_DIV - 1)) begin
                        div_q   <= '0;
                        shift_q <= {SDOUT, shift_q[CFG_WIDTH-1:1]};
                        if (bit_q == BW'(CFG_WIDTH - 1)) begin
                            rb_q    <= {SDOUT, shift_q[CFG_WIDTH-1:1]};
                            bit_q   <= '0;
                            state_q <= ST_UPDATE;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            state_q <= ST_SHIFT_LO;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (div_q == DW'(2 * SCLK_DIV - 1)) begin
                        div_q   <= '0;
                        tmo_q   <= '0;
                        state_q <= ST_WAIT_LOCK;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    // A lock success on the timeout cycle takes priority
                    if (lock_good) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_q <= retry_q + 1'b1;
                            shift_q <= shadow_q;
                            bit_q   <= '0;
                            div_q   <= '0;
                            state_q <= ST_SHIFT_LO;
                        end else begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign RETRIES = retry_q;
    assign CFG_RB  = rb_q;
    assign MODE    = mode_q;
    assign SCLK    = sclk_q;
    assign SDIN    = sdin_q;
    assign SSHIFT  = sshift_q;
    assign SUPDATE = supd_q;
    assign LOCK_OK = lock_s && !busy_q;

endmodule
